cache_line_controller: RTL
==========================

# cache_line_controller

Sequencing controller for the 4-line fully associative cache and its square-matrix LRU replacement unit. The block accepts one read request at a time and compares the tag against four stored lines. On a hit it returns data and marks that line most-recently-used. On a miss it fetches the line from backing memory, overwrites the victim line that the LRU unit names, then responds. It sits between the CPU-side request port and the LRU unit plus the memory port.

## Interface
Parameters:
- TAG_W, 8, address/tag width (fully associative, so the whole address is the tag)
- DATA_W, 8, line data width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  1  request present
- req_addr  in  TAG_W  request address/tag
- req_ready  out  1  controller can accept a request (high only in IDLE)
- resp_valid  out  1  one-cycle pulse carrying the result
- resp_data  out  DATA_W  read data, valid with resp_valid
- resp_hit  out  1  1 = hit, 0 = serviced by a fill; valid with resp_valid
- mem_req  out  1  fill request to backing memory
- mem_addr  out  TAG_W  fill address, stable while mem_req is high
- mem_ack  in  1  memory returns data this cycle
- mem_data  in  DATA_W  fill data, valid with mem_ack
- lru_update  out  1  one-cycle strobe; the LRU unit updates its matrix only when this is high
- lru_hit  out  1  1 = touch lru_index, 0 = touch the LRU unit's own victim
- lru_index  out  2  line that hit
- lru_victim  in  2  current least-recently-used line from the LRU unit

## Operation
- State per line i (0..3): valid[i], tag[i], data[i]. Reset clears all valid bits. Tag and data contents are don't-care after reset.
- FSM states: IDLE, LOOKUP, FILL, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid is high, latch req_addr into addr_q and go to LOOKUP.
- LOOKUP:
  - Compare addr_q against tag[i] for all lines with valid[i]=1.
  - If any line matches, call the result a hit; take the lowest matching index (duplicate tags cannot occur by construction). Latch data, set hit_q=1, pulse lru_update with lru_hit=1 and lru_index equal to the matching index, then go to RESP.
  - On a miss, latch victim_q. victim_q is the lowest invalid line if any line is invalid, otherwise lru_victim. Go to FILL.
- FILL:
  - mem_req=1, mem_addr=addr_q.
  - Stay in FILL until mem_ack.
  - On mem_ack:
    - write tag[victim_q]=addr_q, data[victim_q]=mem_data, valid[victim_q]=1;
    - latch mem_data for the response and set hit_q=0;
    - pulse lru_update with lru_hit=1 and lru_index=victim_q, which makes the filled line MRU;
    - go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
- lru_hit=0 is never driven with lru_update=1 by this block. That encoding is reserved.
- mem_ack outside FILL is ignored.
- req_valid outside IDLE is ignored. The requester holds it until it sees req_ready.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_hit=0, mem_req=0, mem_addr=0, lru_update=0, lru_hit=0, lru_index=0. FSM is in IDLE.
- Hit latency: request accepted at edge N → LOOKUP in cycle N+1 → resp_valid in cycle N+2. Throughput is one request per 3 cycles.
- Miss latency: 3 cycles plus the memory wait.
  - mem_req rises in the cycle after LOOKUP.
  - resp_valid comes in the cycle after mem_ack.
  - mem_ack on the first FILL cycle gives resp_valid at N+3.
- mem_req falls in the cycle after mem_ack is sampled. It never re-asserts for the same request.
- All outputs are registered or decoded from state only. There is no combinational path from req_valid or mem_ack to any output.
- Reset asserted in FILL:
  - mem_req drops at once;
  - all valid bits clear;
  - no partial line write takes place;
  - no response is issued.

## Structure
- Shared package `cache_pkg`: FSM state enum, the LINES=4 constant, and the line index width of 2.
- One natural sub-module, `tag_compare4`: a combinational 4-way tag match that outputs hit and the 2-bit index. It is reused by future write and flush paths.
- The LRU unit is external. This block only drives its strobe and index.

## Test plan
- Reset, then request 0x10: miss, victim line 0, mem_req with mem_addr=0x10, mem_ack with 0xA5 → resp_data=0xA5, resp_hit=0; then re-request 0x10 → hit with 0xA5, resp_valid exactly 2 cycles after acceptance.
- Fill 0x10, 0x20, 0x30, 0x40 → lines 0-3 filled in order with no lru_victim use; touch 0x10; request 0x50 with lru_victim=1 → 0x20 is evicted; a request for 0x20 then misses.
- Delay mem_ack by 5 cycles → mem_req and mem_addr stay stable throughout; req_ready=0; a stray req_valid is ignored.
- A mem_ack pulse during IDLE or LOOKUP → no state change, no line write.
- Assert reset during FILL → mem_req=0 in the same cycle; request for the same address afterward misses.
- Hit on line 2 → exactly one lru_update pulse with lru_hit=1 and lru_index=2; no mem_req.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// =============================================================================
// Package     : cache_pkg
// Description : Shared FSM state type, geometry constants and helpers for the
//               4-line fully associative cache controller.
// Revision    : 1.0
// =============================================================================
package cache_pkg;

    localparam int LINES = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Lowest-numbered line whose valid bit is clear (0 when all are valid).
    function automatic logic [IDX_W-1:0] first_free(input logic [LINES-1:0] valid);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (!valid[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tag_compare4.sv
`default_nettype none
// =============================================================================
// Module      : tag_compare4
// Description : Combinational 4-way tag match; reports hit and the lowest
//               matching line index.
// Revision    : 1.0
// =============================================================================
module tag_compare4
    import cache_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic [TAG_W-1:0]             addr,
    input  logic [LINES-1:0]             valid,
    input  logic [LINES-1:0][TAG_W-1:0]  tags,
    output logic                         hit,
    output logic [IDX_W-1:0]             index
);

    logic [LINES-1:0] w_match;

    generate
        for (genvar g = 0; g < LINES; g++) begin : g_match
            assign w_match[g] = valid[g] && (tags[g] == addr);
        end
    endgenerate

    always_comb begin
        hit   = |w_match;
        index = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (w_match[i]) index = IDX_W'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_line_controller.sv
`default_nettype none
// =============================================================================
// Module      : cache_line_controller
// Description : Request sequencer for a 4-line fully associative cache with an
//               external LRU unit and a single-beat fill port.
// Revision    : 1.0
// =============================================================================
module cache_line_controller
    import cache_pkg::*;
#(
    parameter int TAG_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [TAG_W-1:0]  req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,
    output logic              mem_req,
    output logic [TAG_W-1:0]  mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              lru_update,
    output logic              lru_hit,
    output logic [1:0]        lru_index,
    input  logic [1:0]        lru_victim
);

    state_t                        r_state;
    state_t                        w_next;
    logic [TAG_W-1:0]              r_addr;
    logic [IDX_W-1:0]              r_victim;
    logic [LINES-1:0]              r_valid;
    logic [LINES-1:0][TAG_W-1:0]   r_tag;
    logic [LINES-1:0][DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]             r_resp_data;
    logic                          r_resp_hit;
    logic                          r_lru_update;
    logic                          r_lru_hit;
    logic [IDX_W-1:0]              r_lru_index;
    logic                          w_hit;
    logic [IDX_W-1:0]              w_hit_idx;

    tag_compare4 #(.TAG_W(TAG_W)) u_tag_compare (
        .addr  (r_addr),
        .valid (r_valid),
        .tags  (r_tag),
        .hit   (w_hit),
        .index (w_hit_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next = ST_LOOKUP;
            ST_LOOKUP: w_next = w_hit ? ST_RESP : ST_FILL;
            ST_FILL:   if (mem_ack) w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_victim     <= '0;
            r_valid      <= '0;
            r_resp_data  <= '0;
            r_resp_hit   <= 1'b0;
            r_lru_update <= 1'b0;
            r_lru_hit    <= 1'b0;
            r_lru_index  <= '0;
        end else begin
            r_lru_update <= 1'b0;
            r_lru_hit    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) r_addr <= req_addr;
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_resp_data  <= r_data[w_hit_idx];
                        r_resp_hit   <= 1'b1;
                        r_lru_update <= 1'b1;
                        r_lru_hit    <= 1'b1;
                        r_lru_index  <= w_hit_idx;
                    end else begin
                        // Empty lines are consumed before the LRU unit is consulted.
                        r_victim <= (&r_valid) ? lru_victim : first_free(r_valid);
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        r_valid[r_victim] <= 1'b1;
                        r_resp_data       <= mem_data;
                        r_resp_hit        <= 1'b0;
                        r_lru_update      <= 1'b1;
                        r_lru_hit         <= 1'b1;
                        r_lru_index       <= r_victim;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line payload needs no reset: it is only visible through a set valid bit.
    always_ff @(posedge clk) begin
        if (r_state == ST_FILL && mem_ack) begin
            r_tag[r_victim]  <= r_addr;
            r_data[r_victim] <= mem_data;
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign mem_req    = (r_state == ST_FILL);
    assign mem_addr   = r_addr;
    assign resp_data  = r_resp_data;
    assign resp_hit   = r_resp_hit;
    assign lru_update = r_lru_update;
    assign lru_hit    = r_lru_hit;
    assign lru_index  = r_lru_index;

endmodule
`default_nettype wire
